// File: rtl/gpio_defaults_loader.sv
// Shadow store of per-pad GPIO configuration words with a serial loader that
// re-shifts the whole image into the GPIO control-block chain on request.
module gpio_defaults_loader #(
    parameter int NUM_GPIO = 19,
    parameter int CFG_WIDTH = 13,
    parameter logic [NUM_GPIO*CFG_WIDTH-1:0] GPIO_CONFIG_INIT = {NUM_GPIO{13'h0402}},
    parameter int CLK_DIV = 2,
    parameter int IDXW = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          cfg_wr_en,
    input  logic [IDXW-1:0]               cfg_wr_idx,
    input  logic [CFG_WIDTH-1:0]          cfg_wr_data,
    input  logic                          load_start,
    output logic                          busy,
    output logic                          done,
    output logic                          serial_clock,
    output logic                          serial_data,
    output logic                          serial_load,
    output logic [NUM_GPIO*CFG_WIDTH-1:0] gpio_defaults
);

    localparam int N = NUM_GPIO * CFG_WIDTH;
    localparam int BITW = $clog2(N + 1);
    localparam int DIVW = $clog2(CLK_DIV + 1);
    localparam logic [BITW-1:0] BIT_LAST = BITW'(N - 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD, DONE} state_t;

    state_t          state;
    logic [N-1:0]    shift_reg;
    logic [N-1:0]    shift_next;
    logic [BITW-1:0] bit_cnt;
    logic [DIVW-1:0] div_cnt;

    assign shift_next = shift_reg << 1;

    // Shadow image; the loop form makes out-of-range indices fall through untouched.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            gpio_defaults <= GPIO_CONFIG_INIT;
        end else if (cfg_wr_en) begin
            for (int i = 0; i < NUM_GPIO; i++) begin
                if (cfg_wr_idx == IDXW'(i)) begin
                    gpio_defaults[i*CFG_WIDTH +: CFG_WIDTH] <= cfg_wr_data;
                end
            end
        end
    end

    // serial_clock doubles as the phase flag: low phase holds data, high phase is the strobe.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load_start) begin
                        shift_reg    <= gpio_defaults;
                        serial_data  <= gpio_defaults[N-1];
                        serial_clock <= 1'b0;
                        bit_cnt      <= '0;
                        div_cnt      <= '0;
                        busy         <= 1'b1;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!serial_clock) begin
                            serial_clock <= 1'b1;
                        end else if (bit_cnt == BIT_LAST) begin
                            serial_clock <= 1'b0;
                            serial_data  <= 1'b0;
                            serial_load  <= 1'b1;
                            state        <= LOAD;
                        end else begin
                            serial_clock <= 1'b0;
                            shift_reg    <= shift_next;
                            serial_data  <= shift_next[N-1];
                            bit_cnt      <= bit_cnt + 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt     <= '0;
                        serial_load <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_defaults_loader.sv
// Directed bench for gpio_defaults_loader: shadow writes, serial load framing,
// writes and load requests during a sequence, mid-sequence reset, and a slower divider.
module tb_gpio_defaults_loader;

    localparam logic [12:0] INIT_WORD = 13'h0402;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Main instance: 2 pads, CLK_DIV=1
    logic        a_resetn, a_wr_en, a_start;
    logic [0:0]  a_wr_idx;
    logic [12:0] a_wr_data;
    logic        a_busy, a_done, a_sclk, a_sdata, a_sload;
    logic [25:0] a_gpio;

    gpio_defaults_loader #(.NUM_GPIO(2), .CFG_WIDTH(13), .CLK_DIV(1)) dut_a (
        .clk(clk), .resetn(a_resetn), .cfg_wr_en(a_wr_en), .cfg_wr_idx(a_wr_idx),
        .cfg_wr_data(a_wr_data), .load_start(a_start), .busy(a_busy), .done(a_done),
        .serial_clock(a_sclk), .serial_data(a_sdata), .serial_load(a_sload),
        .gpio_defaults(a_gpio));

    // Slow-divider instance: 2 pads, CLK_DIV=3
    logic        c_resetn, c_wr_en, c_start;
    logic [0:0]  c_wr_idx;
    logic [12:0] c_wr_data;
    logic        c_busy, c_done, c_sclk, c_sdata, c_sload;
    logic [25:0] c_gpio;

    gpio_defaults_loader #(.NUM_GPIO(2), .CFG_WIDTH(13), .CLK_DIV(3)) dut_c (
        .clk(clk), .resetn(c_resetn), .cfg_wr_en(c_wr_en), .cfg_wr_idx(c_wr_idx),
        .cfg_wr_data(c_wr_data), .load_start(c_start), .busy(c_busy), .done(c_done),
        .serial_clock(c_sclk), .serial_data(c_sdata), .serial_load(c_sload),
        .gpio_defaults(c_gpio));

    // Three pads so a 2-bit index can address the out-of-range value 3
    logic        d_resetn, d_wr_en, d_start;
    logic [1:0]  d_wr_idx;
    logic [12:0] d_wr_data;
    logic        d_busy, d_done, d_sclk, d_sdata, d_sload;
    logic [38:0] d_gpio;

    gpio_defaults_loader #(.NUM_GPIO(3), .CFG_WIDTH(13), .CLK_DIV(1)) dut_d (
        .clk(clk), .resetn(d_resetn), .cfg_wr_en(d_wr_en), .cfg_wr_idx(d_wr_idx),
        .cfg_wr_data(d_wr_data), .load_start(d_start), .busy(d_busy), .done(d_done),
        .serial_clock(d_sclk), .serial_data(d_sdata), .serial_load(d_sload),
        .gpio_defaults(d_gpio));

    // Capture the data bit seen by the chain at every shift-clock rising edge
    logic a_bits_q[$];
    logic c_bits_q[$];
    always @(posedge a_sclk) a_bits_q.push_back(a_sdata);
    always @(posedge c_sclk) c_bits_q.push_back(c_sdata);

    typedef struct {
        logic        wr_en;
        logic [0:0]  idx;
        logic [12:0] data;
        logic [25:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        a_wr_en   = v.wr_en;
        a_wr_idx  = v.idx;
        a_wr_data = v.data;
        tick();
        a_wr_en = 1'b0;
    endtask

    // Start a sequence on dut_a and follow it to its done pulse (returns on the done sample)
    task automatic run_a(input bit hold, input int wr_at, input logic [12:0] wr_d,
                         output int lat, output int busy_n, output int load_n, output int hi_n,
                         output int bad_n, output logic [25:0] bits, output int nbits,
                         output bit got_done);
        a_bits_q.delete();
        lat = 0; busy_n = 0; load_n = 0; hi_n = 0; bad_n = 0; got_done = 0; bits = '0;
        a_start = 1'b1;
        tick();
        if (!hold) a_start = 1'b0;
        for (int c = 0; c < 400 && !got_done; c++) begin
            if (a_busy && busy_n == 0) lat = c + 1;
            if (a_busy) busy_n++;
            if (a_sload) load_n++;
            if (a_sclk) hi_n++;
            if (a_sload && a_sclk) bad_n++;
            if (a_done) begin
                got_done = 1;
                if (a_busy) bad_n++;
            end else begin
                if (wr_at > 0 && busy_n == wr_at) begin
                    a_wr_en = 1'b1; a_wr_idx = 1'b0; a_wr_data = wr_d;
                end
                tick();
                a_wr_en = 1'b0;
            end
        end
        nbits = a_bits_q.size();
        foreach (a_bits_q[i]) bits = {bits[24:0], a_bits_q[i]};
    endtask

    task automatic run_c(output int busy_n, output int load_n, output int hi_n,
                         output logic [25:0] bits, output int nbits, output bit got_done);
        c_bits_q.delete();
        busy_n = 0; load_n = 0; hi_n = 0; got_done = 0; bits = '0;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        for (int c = 0; c < 800 && !got_done; c++) begin
            if (c_busy) busy_n++;
            if (c_sload) load_n++;
            if (c_sclk) hi_n++;
            if (c_done) got_done = 1;
            else tick();
        end
        nbits = c_bits_q.size();
        foreach (c_bits_q[i]) bits = {bits[24:0], c_bits_q[i]};
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, busy_n, load_n, hi_n, bad_n, nbits, done_n;
        bit got_done;
        logic [25:0] bits;

        a_resetn = 0; a_wr_en = 0; a_wr_idx = '0; a_wr_data = '0; a_start = 0;
        c_resetn = 0; c_wr_en = 0; c_wr_idx = '0; c_wr_data = '0; c_start = 0;
        d_resetn = 0; d_wr_en = 0; d_wr_idx = '0; d_wr_data = '0; d_start = 0;
        tick();
        tick();

        checkOutput("reset_gpio", a_gpio, {INIT_WORD, INIT_WORD});
        checkOutput("reset_busy", a_busy, 0);
        checkOutput("reset_done", a_done, 0);
        checkOutput("reset_sclk", a_sclk, 0);
        checkOutput("reset_sdata", a_sdata, 0);
        checkOutput("reset_sload", a_sload, 0);
        a_resetn = 1; c_resetn = 1; d_resetn = 1;
        tick();

        // Shadow write table; the last two entries leave the image for the first load
        vecs[0] = '{1'b1, 1'b1, 13'h1FFF, {13'h1FFF, INIT_WORD}};
        vecs[1] = '{1'b1, 1'b0, 13'h0000, {13'h1FFF, 13'h0000}};
        vecs[2] = '{1'b0, 1'b0, 13'h0555, {13'h1FFF, 13'h0000}};
        vecs[3] = '{1'b1, 1'b0, 13'h1555, {13'h1FFF, 13'h1555}};
        vecs[4] = '{1'b1, 1'b1, 13'h0AAA, {13'h0AAA, 13'h1555}};
        vecs[5] = '{1'b1, 1'b1, 13'h1FFF, {13'h1FFF, 13'h1555}};
        vecs[6] = '{1'b1, 1'b0, 13'h0000, {13'h1FFF, 13'h0000}};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("shadow_vec%0d", i), a_gpio, vecs[i].exp);
        end

        // Plain load of {1FFF,0000}
        run_a(0, 0, 13'h0, lat, busy_n, load_n, hi_n, bad_n, bits, nbits, got_done);
        checkOutput("load_done_seen", got_done, 1);
        checkOutput("load_busy_latency", lat, 1);
        checkOutput("load_busy_cycles", busy_n, 53);
        checkOutput("load_strobe_cycles", load_n, 1);
        checkOutput("load_sclk_high_cycles", hi_n, 26);
        checkOutput("load_framing_errors", bad_n, 0);
        checkOutput("load_nbits", nbits, 26);
        checkOutput("load_bits", bits, {13'h1FFF, 13'h0000});
        tick();
        checkOutput("load_done_width", a_done, 0);

        // Write to pad 0 mid-shift must not disturb the bits in flight
        run_a(0, 10, 13'h0ABC, lat, busy_n, load_n, hi_n, bad_n, bits, nbits, got_done);
        checkOutput("wrbusy_done_seen", got_done, 1);
        checkOutput("wrbusy_busy_cycles", busy_n, 53);
        checkOutput("wrbusy_bits", bits, {13'h1FFF, 13'h0000});
        tick();
        checkOutput("wrbusy_gpio", a_gpio, {13'h1FFF, 13'h0ABC});
        run_a(0, 0, 13'h0, lat, busy_n, load_n, hi_n, bad_n, bits, nbits, got_done);
        checkOutput("reload_bits", bits, {13'h1FFF, 13'h0ABC});
        tick();

        // load_start held high: one sequence per IDLE entry
        run_a(1, 0, 13'h0, lat, busy_n, load_n, hi_n, bad_n, bits, nbits, got_done);
        checkOutput("held1_done_seen", got_done, 1);
        checkOutput("held1_busy_cycles", busy_n, 53);
        checkOutput("held1_bits", bits, {13'h1FFF, 13'h0ABC});
        tick();
        checkOutput("held_gap_busy", a_busy, 0);
        checkOutput("held_gap_done", a_done, 0);
        run_a(1, 0, 13'h0, lat, busy_n, load_n, hi_n, bad_n, bits, nbits, got_done);
        checkOutput("held2_latency", lat, 1);
        checkOutput("held2_busy_cycles", busy_n, 53);
        checkOutput("held2_bits", bits, {13'h1FFF, 13'h0ABC});
        a_start = 1'b0;
        tick();
        tick();
        checkOutput("held_release_idle", a_busy, 0);

        // Reset during bit 7 (a '1' bit, low phase)
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (14) tick();
        checkOutput("midreset_pre_busy", a_busy, 1);
        checkOutput("midreset_pre_sdata", a_sdata, 1);
        a_resetn = 1'b0;
        tick();
        checkOutput("midreset_sclk", a_sclk, 0);
        checkOutput("midreset_sdata", a_sdata, 0);
        checkOutput("midreset_sload", a_sload, 0);
        checkOutput("midreset_busy", a_busy, 0);
        checkOutput("midreset_gpio", a_gpio, {INIT_WORD, INIT_WORD});
        a_resetn = 1'b1;
        done_n = 0;
        for (int i = 0; i < 60; i++) begin
            if (a_done || a_busy) done_n++;
            tick();
        end
        checkOutput("midreset_no_done", done_n, 0);

        // CLK_DIV=3 rerun of the plain load
        c_wr_en = 1'b1; c_wr_idx = 1'b1; c_wr_data = 13'h1FFF;
        tick();
        c_wr_idx = 1'b0; c_wr_data = 13'h0000;
        tick();
        c_wr_en = 1'b0;
        run_c(busy_n, load_n, hi_n, bits, nbits, got_done);
        checkOutput("div3_done_seen", got_done, 1);
        checkOutput("div3_busy_cycles", busy_n, 159);
        checkOutput("div3_strobe_cycles", load_n, 3);
        checkOutput("div3_sclk_high_cycles", hi_n, 78);
        checkOutput("div3_nbits", nbits, 26);
        checkOutput("div3_bits", bits, {13'h1FFF, 13'h0000});

        // Out-of-range index ignored, in-range last pad accepted
        d_wr_en = 1'b1; d_wr_idx = 2'd3; d_wr_data = 13'h1111;
        tick();
        d_wr_en = 1'b0;
        checkOutput("oor_idx3_ignored", d_gpio, {INIT_WORD, INIT_WORD, INIT_WORD});
        d_wr_en = 1'b1; d_wr_idx = 2'd2;
        tick();
        d_wr_en = 1'b0;
        checkOutput("oor_idx2_written", d_gpio, {13'h1111, INIT_WORD, INIT_WORD});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
